tt_um_uwasic_onboarding_matthew_chen: RTL and testbench

Tiny Tapeout user tile with an SPI-controlled register file driving a 16-channel output/PWM peripheral. An external SPI controller writes five 8-bit configuration registers. The registers enable each of 16 outputs statically or with a shared ~3 kHz PWM waveform of programmable duty cycle. Outputs appear on uo_out (channels 7..0) and uio_out (channels 15..8).

---
 rtl/tt_um_uwasic_onboarding_matthew_chen.sv | 157 +++++++++++++++
 tb/tb_tt_um_uwasic_onboarding_matthew_chen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_uwasic_onboarding_matthew_chen.sv
// ---------------------------------------------------------------------------
// tt_um_uwasic_onboarding_matthew_chen
//
// Tiny Tapeout tile: SPI-written register file driving 16 output channels.
// Each channel is either off, statically on, or gated by a shared ~3 kHz PWM
// waveform whose duty cycle is programmable.
//
// Ports:
//   clk        10 MHz system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ena        tile select (ignored)
//   ui_in      [0]=SCLK, [1]=COPI, [2]=nCS, [7:3] unused
//   uo_out     output channels 7..0
//   uio_in     unused
//   uio_out    output channels 15..8
//   uio_oe     constant 8'hFF
//   test_mode  [0]=synchronized nCS low, [1]=raw PWM waveform
//
// SPI is mode 0, MSB first, 16-bit frames: {rw, addr[6:0], data[7:0]}.
// There is no valid/ready handshake anywhere in this block: the SPI
// controller owns the timing and a frame takes effect when nCS rises.
// The register map is 0x00/0x01 en_out, 0x02/0x03 en_pwm, 0x04 duty.
// ---------------------------------------------------------------------------
module tt_um_uwasic_onboarding_matthew_chen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [1:0] test_mode
);

  // 2-flop synchronizers plus one extra stage for edge detection
  logic sclk_s1, sclk_s2, sclk_prev;
  logic copi_s1, copi_s2;
  logic ncs_s1,  ncs_s2,  ncs_prev;

  logic [15:0] shift_q;
  logic [4:0]  bit_cnt;

  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;

  logic [3:0]  presc;
  logic [7:0]  pwm_cnt;
  logic        pwm;

  logic [15:0] out_q;
  logic [1:0]  tm_q;

  logic sclk_rise, ncs_fall, ncs_rise, commit;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1   <= 1'b0;
      sclk_s2   <= 1'b0;
      sclk_prev <= 1'b0;
      copi_s1   <= 1'b0;
      copi_s2   <= 1'b0;
      ncs_s1    <= 1'b1;
      ncs_s2    <= 1'b1;
      ncs_prev  <= 1'b1;
    end else begin
      sclk_s1   <= ui_in[0];
      sclk_s2   <= sclk_s1;
      sclk_prev <= sclk_s2;
      copi_s1   <= ui_in[1];
      copi_s2   <= copi_s1;
      ncs_s1    <= ui_in[2];
      ncs_s2    <= ncs_s1;
      ncs_prev  <= ncs_s2;
    end
  end

  assign sclk_rise = ~sclk_prev & sclk_s2;
  assign ncs_fall  = ncs_prev & ~ncs_s2;
  assign ncs_rise  = ~ncs_prev & ncs_s2;

  // A frame is only accepted when exactly 16 bits arrived; the counter
  // saturating at 17 is what lets over-long frames be told apart.
  assign commit = ncs_rise && (bit_cnt == 5'd16) && shift_q[15]
                  && (shift_q[14:8] <= 7'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 16'h0000;
      bit_cnt <= 5'd0;
    end else if (ncs_fall) begin
      shift_q <= 16'h0000;
      bit_cnt <= 5'd0;
    end else if (sclk_rise && !ncs_s2) begin
      if (bit_cnt < 5'd16) begin
        shift_q <= {shift_q[14:0], copi_s2};
      end
      if (bit_cnt < 5'd17) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out <= 16'h0000;
      en_pwm <= 16'h0000;
      duty   <= 8'h00;
    end else if (commit) begin
      // address already bounded to 0..4, low three bits select the register
      case (shift_q[10:8])
        3'd0:    en_out[7:0]  <= shift_q[7:0];
        3'd1:    en_out[15:8] <= shift_q[7:0];
        3'd2:    en_pwm[7:0]  <= shift_q[7:0];
        3'd3:    en_pwm[15:8] <= shift_q[7:0];
        3'd4:    duty         <= shift_q[7:0];
        default: ;
      endcase
    end
  end

  // 13-cycle prescaler ticking an 8-bit free-running counter: 3328 cycles/period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= 4'd0;
      pwm_cnt <= 8'd0;
    end else if (presc == 4'd12) begin
      presc   <= 4'd0;
      pwm_cnt <= pwm_cnt + 8'd1;
    end else begin
      presc   <= presc + 4'd1;
    end
  end

  // 0xFF is special-cased so full scale means always high
  assign pwm = (duty == 8'hFF) || (pwm_cnt < duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 16'h0000;
      tm_q  <= 2'b00;
    end else begin
      out_q <= en_out & (~en_pwm | {16{pwm}});
      tm_q  <= {pwm, ~ncs_s2};
    end
  end

  assign uo_out    = out_q[7:0];
  assign uio_out   = out_q[15:8];
  assign uio_oe    = 8'hFF;
  assign test_mode = tm_q;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_matthew_chen.sv
// ---------------------------------------------------------------------------
// Bench for tt_um_uwasic_onboarding_matthew_chen. SPI frames are driven by
// tasks; after each committing (or rejected) frame the expected 16-bit
// channel state is pushed into exp_q with a due cycle, and an independent
// monitor pops and compares once the due cycle is reached. PWM timing is
// measured directly from uo_out/uio_out.
// ---------------------------------------------------------------------------
module tb_tt_um_uwasic_onboarding_matthew_chen;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [1:0] test_mode;

  always #50 clk = ~clk;  // 10 MHz

  assign ui_in = {5'b00000, ncs, copi, sclk};

  tt_um_uwasic_onboarding_matthew_chen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (1'b1),
    .ui_in     (ui_in),
    .uo_out    (uo_out),
    .uio_in    (8'h00),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe),
    .test_mode (test_mode)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  int          due_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compares channel outputs when an expectation falls due
  always @(negedge clk) begin
    if (exp_q.size() > 0 && cyc >= due_q[0]) begin
      logic [15:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      void'(due_q.pop_front());
      check(n, {uio_out, uo_out}, e);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift n bits (bits[n-1] first) in one nCS window.
  task automatic spi_bits(input logic [16:0] bits, input int n);
    ncs = 1'b0;
    wait_clk(4);
    check("ncs_sync_active", {31'd0, test_mode[0]}, 32'd1);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    wait_clk(4);
    ncs = 1'b1;
  endtask

  // Drive a frame; when do_chk, expect {uio_out,uo_out}==exp 4 clk after nCS rise.
  task automatic spi_frame(input logic [16:0] bits, input int n, input bit do_chk,
                           input logic [15:0] exp, input string name);
    spi_bits(bits, n);
    if (do_chk) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + 4);
      name_q.push_back(name);
    end
    wait_clk(8);
  endtask

  task automatic measure_pwm(output int hi, output int per, output bit to);
    int n;
    logic p;
    to = 1'b0;
    n = 0;
    do begin
      p = uo_out[0];
      @(negedge clk);
      n++;
    end while (!(p == 1'b0 && uo_out[0] == 1'b1) && n < 8000);
    if (n >= 8000) to = 1'b1;
    hi = 0;
    while (uo_out[0] == 1'b1 && hi < 8000) begin
      @(negedge clk);
      hi++;
    end
    per = hi;
    while (uo_out[0] == 1'b0 && per < 8000) begin
      @(negedge clk);
      per++;
    end
    if (per >= 8000) to = 1'b1;
  endtask

  task automatic hold_const(input string name, input logic exp_bit);
    int bad = 0;
    for (int i = 0; i < 2 * 3328; i++) begin
      @(negedge clk);
      if (uo_out[0] !== exp_bit) bad++;
    end
    check(name, bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi, per, bad_uo, bad_tm, hi_cnt, bad_lvl, w;
    bit to;

    wait_clk(5);
    check("rst_uo",   uo_out, 8'h00);
    check("rst_uio",  uio_out, 8'h00);
    check("rst_oe",   uio_oe, 8'hFF);
    check("rst_tm",   test_mode, 2'b00);
    rst_n = 1'b1;
    wait_clk(5);
    check("post_rst_out", {uio_out, uo_out}, 16'h0000);

    // static writes
    spi_frame(17'h080F0, 16, 1, 16'h00F0, "wr_en_lo");
    spi_frame(17'h081CC, 16, 1, 16'hCCF0, "wr_en_hi");

    // rejected frames
    spi_frame(17'h000FF, 16, 1, 16'hCCF0, "rej_read");
    spi_frame(17'h0B0AA, 16, 1, 16'hCCF0, "rej_addr30");
    spi_frame(17'h08511, 16, 1, 16'hCCF0, "rej_addr05");
    spi_frame(17'h0402A, 15, 1, 16'hCCF0, "rej_15bit");  // top 15 bits of 0x8055
    spi_frame(17'h10155, 17, 1, 16'hCCF0, "rej_17bit");  // 0x80AA then one extra bit
    ncs = 1'b0;
    wait_clk(8);
    ncs = 1'b1;
    exp_q.push_back(16'hCCF0);
    due_q.push_back(cyc + 4);
    name_q.push_back("ncs_no_sclk");
    wait_clk(8);

    // PWM 50% on channel 0 (duty still 0 while en_pwm goes in)
    spi_frame(17'h08100, 16, 1, 16'h00F0, "clr_en_hi");
    spi_frame(17'h08001, 16, 1, 16'h0001, "en_ch0");
    spi_frame(17'h08201, 16, 1, 16'h0000, "pwm_ch0_duty0");
    spi_frame(17'h08480, 16, 0, 16'h0000, "");
    measure_pwm(hi, per, to);
    check("pwm50_timeout", {31'd0, to}, 32'd0);
    check("pwm50_high_ok", (hi >= 1663 && hi <= 1665), 1);
    check("pwm50_period_ok", (per >= 3327 && per <= 3329), 1);

    // duty extremes
    spi_frame(17'h08400, 16, 1, 16'h0000, "duty00");
    hold_const("duty00_const0", 1'b0);
    spi_frame(17'h084FF, 16, 1, 16'h0001, "dutyFF");
    hold_const("dutyFF_const1", 1'b1);

    // mixed channels
    spi_frame(17'h08200, 16, 1, 16'h0001, "clr_pwm_lo");
    spi_frame(17'h080FF, 16, 1, 16'h00FF, "en_lo_ff");
    spi_frame(17'h08440, 16, 1, 16'h00FF, "duty40");
    spi_frame(17'h081FF, 16, 1, 16'hFFFF, "en_hi_ff");
    spi_frame(17'h083FF, 16, 0, 16'h0000, "");
    bad_uo = 0; bad_tm = 0; hi_cnt = 0; bad_lvl = 0;
    for (int i = 0; i < 2 * 3328; i++) begin
      @(negedge clk);
      if (uo_out !== 8'hFF) bad_uo++;
      if (test_mode[1] !== uio_out[0]) bad_tm++;
      if (uio_out == 8'hFF) hi_cnt++;
      else if (uio_out !== 8'h00) bad_lvl++;
    end
    check("mix_uo_steady", bad_uo, 0);
    check("mix_tm_match", bad_tm, 0);
    check("mix_uio_levels", bad_lvl, 0);
    check("mix_uio_25pct", (hi_cnt >= 1662 && hi_cnt <= 1666), 1);

    // drain scoreboard with a bound
    w = 0;
    while (exp_q.size() > 0 && w < 100) begin
      wait_clk(1);
      w++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
